sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_fill_engine.sv | 71 +++++++
 rtl/sram_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter and its fill engine.
package sram_arb_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 17;
    localparam int unsigned DefStarveMax = 4;

    typedef enum logic [1:0] {
        SrcNone,
        SrcVid,
        SrcGm,
        SrcFill
    } grant_src_e;

    typedef enum logic {
        FillIdle,
        FillRun
    } fill_state_e;

endpackage

// File: rtl/sram_fill_engine.sv
// Block-fill engine: captures base/len/value, then writes one word per granted idle slot.
module sram_fill_engine
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic                  advance_i,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    fill_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
    logic [ADDR_WIDTH-1:0] remain_q, remain_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= FillIdle;
            cursor_q <= '0;
            remain_q <= '0;
            value_q  <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            remain_q <= remain_d;
            value_q  <= value_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        remain_d = remain_q;
        value_d  = value_q;
        case (state_q)
            FillIdle: begin
                if (start_i && (len_i != '0)) begin
                    state_d  = FillRun;
                    cursor_d = base_i;
                    remain_d = len_i;
                    value_d  = value_i;
                end
            end
            FillRun: begin
                // Cursor wraps naturally at the address width.
                if (advance_i) begin
                    cursor_d = cursor_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - ADDR_WIDTH'(1);
                    if (remain_q == ADDR_WIDTH'(1)) begin
                        state_d = FillIdle;
                    end
                end
            end
            default: state_d = FillIdle;
        endcase
    end

    assign busy_o = (state_q == FillRun);
    assign addr_o = cursor_q;
    assign data_o = value_q;

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: video > game > fill, with game anti-starvation.
// Optional request-stall statistics outputs are enabled by defining SRAM_ARB_STATS_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned STARVE_MAX = DefStarveMax
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_valid,
    input  logic                  gm_req,
    input  logic                  gm_we,
    input  logic [ADDR_WIDTH-1:0] gm_addr,
    input  logic [DATA_WIDTH-1:0] gm_wdata,
    output logic                  gm_gnt,
    output logic [DATA_WIDTH-1:0] gm_rdata,
    output logic                  gm_rvalid,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH-1:0] fill_len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_vid_stall,
    output logic [15:0]           stat_gm_wait
`endif
);

    localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);

    grant_src_e            src;
    logic [StarveW-1:0]    starve_q, starve_d;
    logic                  vid_pend_q, vid_pend_d;
    logic                  gm_pend_q, gm_pend_d;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_data;

    sram_fill_engine #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fill (
        .clk_i    (clk),
        .rst_i    (reset),
        .start_i  (fill_start),
        .base_i   (fill_base),
        .len_i    (fill_len),
        .value_i  (fill_value),
        .advance_i(src == SrcFill),
        .busy_o   (fill_busy),
        .addr_o   (fill_addr),
        .data_o   (fill_data)
    );

    always_comb begin
        src = SrcNone;
        // A starved game request preempts video; that video slot is simply lost.
        if (gm_req && (starve_q == StarveLim)) begin
            src = SrcGm;
        end else if (vid_req) begin
            src = SrcVid;
        end else if (gm_req) begin
            src = SrcGm;
        end else if (fill_busy) begin
            src = SrcFill;
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (src)
            SrcVid: begin
                sram_en   = 1'b1;
                sram_addr = vid_addr;
            end
            SrcGm: begin
                sram_en    = 1'b1;
                sram_we    = gm_we;
                sram_addr  = gm_addr;
                sram_wdata = gm_wdata;
            end
            SrcFill: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = fill_addr;
                sram_wdata = fill_data;
            end
            default: ;
        endcase
    end

    assign gm_gnt = (src == SrcGm);

    always_comb begin
        starve_d = starve_q;
        if (!gm_req || gm_gnt) begin
            starve_d = '0;
        end else if (starve_q != StarveLim) begin
            starve_d = starve_q + StarveW'(1);
        end
        vid_pend_d = (src == SrcVid);
        gm_pend_d  = (src == SrcGm) && !gm_we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q   <= '0;
            vid_pend_q <= 1'b0;
            gm_pend_q  <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            vid_pend_q <= vid_pend_d;
            gm_pend_q  <= gm_pend_d;
        end
    end

    assign vid_valid = vid_pend_q;
    assign vid_data  = vid_pend_q ? sram_rdata : '0;
    assign gm_rvalid = gm_pend_q;
    assign gm_rdata  = gm_pend_q ? sram_rdata : '0;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] vid_stall_q, vid_stall_d;
    logic [15:0] gm_wait_q, gm_wait_d;

    always_comb begin
        vid_stall_d = vid_stall_q;
        gm_wait_d   = gm_wait_q;
        if (vid_req && (src != SrcVid) && (vid_stall_q != 16'hFFFF)) begin
            vid_stall_d = vid_stall_q + 16'd1;
        end
        if (gm_req && !gm_gnt && (gm_wait_q != 16'hFFFF)) begin
            gm_wait_d = gm_wait_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_stall_q <= '0;
            gm_wait_q   <= '0;
        end else begin
            vid_stall_q <= vid_stall_d;
            gm_wait_q   <= gm_wait_d;
        end
    end

    assign stat_vid_stall = vid_stall_q;
    assign stat_gm_wait   = gm_wait_q;
`endif

endmodule
